instr_encoder: RTL and testbench

- Inverse of the core's immediate/instruction decode path. Packs instruction fields (format, opcode, registers, functs, 32-bit signed immediate) into a legal RV32I instruction word.
- Scatters immediate bits per format (I/S/B/U/J) and range-checks the immediate.
- Emits the word with a sequential word address over a valid/ready stream.
- Used by the test/boot loader to write instruction memory, and as the round-trip reference for verifying the decoder.

---
 rtl/instr_encoder_pkg.sv | 43 ++++
 rtl/instr_encoder_imm_scatter.sv | 41 ++++
 rtl/instr_encoder.sv | 93 +++++++++
 tb/tb_instr_encoder.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared format codes, immediate range limits and opcodes so the encoder and
// the core's decoder agree on RV32I instruction layout.
package instr_encoder_pkg;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;

   localparam int IMM12_MIN = -2048;
   localparam int IMM12_MAX = 2047;
   localparam int IMM13_MIN = -4096;
   localparam int IMM13_MAX = 4094;
   localparam int IMM21_MIN = -(1 << 20);
   localparam int IMM21_MAX = (1 << 20) - 2;

   localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
   localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
   localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
   localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
   localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
   localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
   localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPCODE_OP     = 7'b0110011;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   function automatic logic fmt_legal(input logic [2:0] fmt);
      return fmt <= FMT_J;
   endfunction

   function automatic logic imm_in_range(input logic [31:0] imm, input int lo, input int hi);
      int v;
      v = int'(imm);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/instr_encoder_imm_scatter.sv
// Places the immediate bits of one RV32I format into their instruction bit
// positions and flags immediates that the format cannot represent.
module imm_scatter
   import instr_encoder_pkg::*;
(
   input  logic [2:0]  fmt,
   input  logic [31:0] imm,
   output logic [31:0] placed,
   output logic        range_err
);

   always_comb begin
      // NOTE: every output gets a default before the case so no path can leave it unassigned and infer a latch.
      placed    = '0;
      range_err = 1'b0;
      case (fmt)
         FMT_I: begin
            placed    = {imm[11:0], 20'b0};
            range_err = !imm_in_range(imm, IMM12_MIN, IMM12_MAX);
         end
         FMT_S: begin
            placed    = {imm[11:5], 13'b0, imm[4:0], 7'b0};
            range_err = !imm_in_range(imm, IMM12_MIN, IMM12_MAX);
         end
         FMT_B: begin
            placed    = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
            range_err = !imm_in_range(imm, IMM13_MIN, IMM13_MAX) || imm[0];
         end
         FMT_U: begin
            placed    = {imm[31:12], 12'b0};
            range_err = |imm[11:0];
         end
         FMT_J: begin
            placed    = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
            range_err = !imm_in_range(imm, IMM21_MIN, IMM21_MAX) || imm[0];
         end
         default: ;  // R carries no immediate; illegal formats are handled by the caller
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Packs instruction fields into an RV32I word and streams it out with a
// sequential word address through a single registered valid/ready stage.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int START_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_fmt,
   input  logic [6:0]        in_opcode,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [2:0]        in_funct3,
   input  logic [6:0]        in_funct7,
   input  logic [31:0]       in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_err,
   output logic [7:0]        err_cnt
);

   logic [31:0] placed;
   logic        range_err;
   logic [31:0] fields;
   logic [31:0] next_instr;
   logic        next_err;
   logic        accept;
   logic        out_hs;

   imm_scatter u_imm_scatter (
      .fmt       (in_fmt),
      .imm       (in_imm),
      .placed    (placed),
      .range_err (range_err)
   );

   // Register fields per format; immediate bit positions are zero here and
   // filled by the scatter, so the two can simply be OR-ed together.
   always_comb begin
      fields = '0;
      case (in_fmt)
         FMT_R:        fields = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
         FMT_I:        fields = {12'b0, in_rs1, in_funct3, in_rd, in_opcode};
         FMT_S, FMT_B: fields = {7'b0, in_rs2, in_rs1, in_funct3, 5'b0, in_opcode};
         FMT_U, FMT_J: fields = {20'b0, in_rd, in_opcode};
         default:      fields = NOP_INSTR;
      endcase
   end

   assign next_instr = fields | placed;
   assign next_err   = !fmt_legal(in_fmt) || range_err;

   assign in_ready = !flush && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign out_hs   = out_valid && out_ready;

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         out_valid <= 1'b0;
         out_instr <= '0;
         out_addr  <= ADDR_W'(START_ADDR);
         out_err   <= 1'b0;
         err_cnt   <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
         out_addr  <= ADDR_W'(START_ADDR);
      end else begin
         if (out_hs) begin
            out_addr <= out_addr + 1'b1;
         end
         if (accept) begin
            out_valid <= 1'b1;
            out_instr <= next_instr;
            out_err   <= next_err;
            if (next_err && (err_cnt != 8'hFF)) begin
               err_cnt <= err_cnt + 8'd1;
            end
         end else if (out_hs) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed literal encodings plus a
// randomized stream compared every cycle against a behavioural model.
module tb_instr_encoder;
   import instr_encoder_pkg::*;

   localparam int ADDR_W     = 3;
   localparam int START_ADDR = 0;
   localparam int NADDR      = 1 << ADDR_W;

   logic              clk;
   logic              rst;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_fmt;
   logic [6:0]        in_opcode;
   logic [4:0]        in_rd;
   logic [4:0]        in_rs1;
   logic [4:0]        in_rs2;
   logic [2:0]        in_funct3;
   logic [6:0]        in_funct7;
   logic [31:0]       in_imm;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_instr;
   logic [ADDR_W-1:0] out_addr;
   logic              out_err;
   logic [7:0]        err_cnt;

   instr_encoder #(.ADDR_W(ADDR_W), .START_ADDR(START_ADDR)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_fmt    (in_fmt),
      .in_opcode (in_opcode),
      .in_rd     (in_rd),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_funct3 (in_funct3),
      .in_funct7 (in_funct7),
      .in_imm    (in_imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_addr  (out_addr),
      .out_err   (out_err),
      .err_cnt   (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference encoding written straight from the field layout of each format.
   function automatic void model_encode(input logic [2:0] fmt, input logic [6:0] op,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [31:0] imm,
                                        output logic [31:0] w, output logic e);
      int v;
      v = int'(imm);
      case (fmt)
         3'd0: begin w = {f7, rs2, rs1, f3, rd, op}; e = 1'b0; end
         3'd1: begin w = {imm[11:0], rs1, f3, rd, op}; e = (v < -2048) || (v > 2047); end
         3'd2: begin w = {imm[11:5], rs2, rs1, f3, imm[4:0], op}; e = (v < -2048) || (v > 2047); end
         3'd3: begin
            w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            e = (v < -4096) || (v > 4094) || (v % 2 != 0);
         end
         3'd4: begin w = {imm[31:12], rd, op}; e = (imm % 4096) != 0; end
         3'd5: begin
            w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            e = (v < -(1 << 20)) || (v > (1 << 20) - 2) || (v % 2 != 0);
         end
         default: begin w = 32'h0000_0013; e = 1'b1; end
      endcase
   endfunction

   // Immediate decoder of the core, used for the round-trip property.
   function automatic logic [31:0] decode_imm(input logic [2:0] fmt, input logic [31:0] w);
      case (fmt)
         3'd1:    return {{20{w[31]}}, w[31:20]};
         3'd2:    return {{20{w[31]}}, w[31:25], w[11:7]};
         3'd3:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
         3'd4:    return {w[31:12], 12'b0};
         3'd5:    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
         default: return 32'h0;
      endcase
   endfunction

   // Behavioural model state: one held word, its address and the error count.
   logic        m_valid  = 1'b0;
   logic [31:0] m_instr  = '0;
   logic        m_err    = 1'b0;
   logic [31:0] m_imm    = '0;
   logic [2:0]  m_fmt    = '0;
   int          m_addr   = START_ADDR;
   int          m_errcnt = 0;
   bit          m_show   = 1'b0;

   initial forever begin
      logic [31:0] w;
      logic        e;
      bit          acc;
      bit          hs;
      @(posedge clk);
      if (rst) begin
         m_valid = 1'b0; m_instr = '0; m_err = 1'b0;
         m_addr = START_ADDR; m_errcnt = 0; m_show = 1'b1;
      end else if (flush) begin
         m_valid = 1'b0; m_addr = START_ADDR; m_show = 1'b0;
      end else begin
         hs  = m_valid && out_ready;
         acc = in_valid && (!m_valid || out_ready);
         if (hs) m_addr = (m_addr + 1) % NADDR;
         if (acc) begin
            model_encode(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, w, e);
            m_valid = 1'b1; m_instr = w; m_err = e; m_imm = in_imm; m_fmt = in_fmt; m_show = 1'b1;
            if (e && m_errcnt < 255) m_errcnt++;
         end else if (hs) begin
            m_valid = 1'b0; m_show = 1'b0;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      check("out_valid", out_valid, m_valid);
      check("out_addr", out_addr, m_addr[ADDR_W-1:0]);
      check("err_cnt", err_cnt, m_errcnt[7:0]);
      if (!rst) check("in_ready", in_ready, !flush && (!m_valid || out_ready));
      if (m_show) begin
         check("out_instr", out_instr, m_instr);
         check("out_err", out_err, m_err);
      end
      if (m_valid && !m_err && (m_fmt inside {[3'd1:3'd5]}))
         check("roundtrip_imm", decode_imm(m_fmt, out_instr), m_imm);
   end

   task automatic set_bundle(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [31:0] imm);
      in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1;
      in_rs2 = rs2; in_funct3 = f3; in_funct7 = f7; in_imm = imm;
   endtask

   // Presents one bundle, waits (bounded) for acceptance, then drops in_valid.
   task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm);
      bit ok;
      ok = 1'b0;
      @(posedge clk); #1;
      set_bundle(fmt, op, rd, rs1, rs2, f3, f7, imm);
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1'b1; break; end
      end
      check("send_accepted", ok, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic rand_bundle();
      int v;
      logic [2:0] fmt;
      fmt = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      case ($urandom_range(0, 7))
         0: v = int'($urandom);
         1: begin
            case ($urandom_range(0, 11))
               0: v = -2048;  1: v = 2047;  2: v = 2048;  3: v = -2049;
               4: v = -4096;  5: v = 4094;  6: v = 4096;  7: v = -4098;
               8: v = -(1 << 20); 9: v = (1 << 20) - 2; 10: v = 1 << 20; default: v = 1;
            endcase
         end
         default: begin
            case (fmt)
               3'd1, 3'd2: v = int'($urandom_range(0, 4095)) - 2048;
               3'd3:       v = (int'($urandom_range(0, 4095)) - 2048) * 2;
               3'd4:       v = int'($urandom & 32'hFFFF_F000);
               3'd5:       v = (int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19)) * 2;
               default:    v = int'($urandom);
            endcase
         end
      endcase
      set_bundle(fmt, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                 3'($urandom), 7'($urandom), 32'(v));
   endtask

   initial begin
      logic [31:0] w;
      logic        e;
      bit          acc;

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      set_bundle(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);

      model_encode(3'd1, OPCODE_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, w, e);
      check("model_addi", w, 32'hFFF0_0093);
      model_encode(3'd3, OPCODE_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, w, e);
      check("model_beq8", w, 32'h0000_0463);
      model_encode(3'd3, OPCODE_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, w, e);
      check("model_beq3_err", e, 1'b1);
      model_encode(3'd5, OPCODE_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, w, e);
      check("model_jal", w, 32'h0010_00EF);
      model_encode(3'd4, OPCODE_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, w, e);
      check("model_lui_err", e, 1'b1);

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_valid", out_valid, 1'b0);
      check("rst_instr", out_instr, 32'h0);
      check("rst_addr", out_addr, START_ADDR);
      check("rst_err", out_err, 1'b0);
      check("rst_errcnt", err_cnt, 8'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      send(3'd1, OPCODE_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
      @(negedge clk);
      check("addi_instr", out_instr, 32'hFFF0_0093);
      check("addi_addr", out_addr, 0);
      check("addi_err", out_err, 1'b0);

      send(3'd3, OPCODE_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
      @(negedge clk);
      check("beq8_instr", out_instr, 32'h0000_0463);
      check("beq8_addr", out_addr, 1);

      send(3'd3, OPCODE_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
      @(negedge clk);
      check("beq3_instr", out_instr, 32'h0000_0163);
      check("beq3_err", out_err, 1'b1);
      check("beq3_errcnt", err_cnt, 8'd1);

      send(3'd5, OPCODE_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
      @(negedge clk);
      check("jal_instr", out_instr, 32'h0010_00EF);
      check("jal_addr", out_addr, 3);

      send(3'd4, OPCODE_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
      @(negedge clk);
      check("lui_instr", out_instr, 32'h1234_52B7);
      check("lui_err", out_err, 1'b0);

      send(3'd4, OPCODE_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001);
      @(negedge clk);
      check("lui_bad_instr", out_instr, 32'h1234_52B7);
      check("lui_bad_err", out_err, 1'b1);
      check("lui_bad_errcnt", err_cnt, 8'd2);

      send(3'd6, OPCODE_OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
      @(negedge clk);
      check("badfmt_instr", out_instr, 32'h0000_0013);
      check("badfmt_err", out_err, 1'b1);

      send(3'd0, OPCODE_OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF);
      @(negedge clk);
      check("add_instr", out_instr, 32'h0020_81B3);
      check("add_addr", out_addr, 7);

      send(3'd2, OPCODE_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFF_FFFC);
      @(negedge clk);
      check("sw_instr", out_instr, 32'hFE20_AE23);
      check("sw_addr_wrap", out_addr, 0);

      // Backpressure: held word stays put while a new bundle waits.
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(3'd1, OPCODE_OP_IMM, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      set_bundle(3'd1, OPCODE_OP_IMM, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6);
      in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("stall_in_ready", in_ready, 1'b0);
         check("stall_instr", out_instr, 32'h0050_0113);
         check("stall_addr", out_addr, 1);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         if (k < 3) set_bundle(3'd1, OPCODE_OP_IMM, 5'(4 + k), 5'd0, 5'd0, 3'd0, 7'd0, 32'(7 + k));
         else in_valid = 1'b0;
         @(negedge clk);
         check("b2b_instr", out_instr, ((6 + k) << 20) | ((3 + k) << 7) | 32'h13);
         check("b2b_addr", out_addr, (2 + k) % NADDR);
      end

      // Flush with a held word: output dropped, address restarts, errors kept.
      send(3'd1, OPCODE_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
      flush = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      check("flush_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
      flush = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check("flush_valid", out_valid, 1'b0);
      check("flush_errcnt", err_cnt, 8'd3);
      send(3'd1, OPCODE_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
      @(negedge clk);
      check("flush_next_addr", out_addr, START_ADDR);

      // Reset while a word is stalled.
      out_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check("rst2_valid", out_valid, 1'b0);
      check("rst2_instr", out_instr, 32'h0);
      check("rst2_addr", out_addr, START_ADDR);
      check("rst2_errcnt", err_cnt, 8'd0);

      // Random stream: the compare process checks every cycle.
      for (int c = 0; c < 12000; c++) begin
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         flush     = ($urandom_range(0, 199) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         if (acc || !in_valid) begin
            in_valid = ($urandom_range(0, 4) != 0);
            if (in_valid) rand_bundle();
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
